// File: rtl/voting_pkg.sv
// -----------------------------------------------------------------------------
// voting_pkg
// Shared definitions for the voting machine result path.
//   NUM_CAND   : number of candidates
//   COUNT_W    : width of each candidate vote counter
//   TOTAL_W    : width of the summed vote total (must be >= COUNT_W+2)
//   cand_idx_t : candidate index, 0 = cand1 .. 3 = cand4
//   state_t    : result evaluator FSM states
// -----------------------------------------------------------------------------
package voting_pkg;

  localparam int NUM_CAND = 4;
  localparam int COUNT_W  = 8;
  localparam int TOTAL_W  = 10;

  typedef logic [1:0] cand_idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // True when two or more bits of the mask are set. Clearing the lowest set
  // bit leaves something behind only if another bit was set.
  function automatic logic multi_bit_set(input logic [NUM_CAND-1:0] mask);
    logic [NUM_CAND-1:0] w_lower;
    w_lower = mask - NUM_CAND'(1);
    return |(mask & w_lower);
  endfunction

endpackage

// File: rtl/vote_result_evaluator.sv
// -----------------------------------------------------------------------------
// vote_result_evaluator
// On a 0->1 transition of mode, snapshots the four candidate counters and
// scans them one per cycle to find the winner, the tie set and the vote total.
// Results are held while mode stays high and cleared when mode returns to 0.
//
// Ports
//   clk                 : system clock, rising edge
//   reset               : asynchronous, active-high reset
//   mode                : 0 = voting mode, 1 = result mode
//   candN_vote_recvd    : candidate N vote count (N = 1..4)
//   busy                : scan in progress
//   result_valid        : result outputs below are valid
//   winner              : winning candidate index (lowest index wins ties)
//   winner_votes        : vote count of the winner
//   tie_mask            : bit i set = candidate i+1 holds the maximum
//   tie                 : more than one candidate holds the maximum
//   total_votes         : sum of all four counts (TOTAL_W >= COUNT_W+2)
// -----------------------------------------------------------------------------
module vote_result_evaluator #(
  parameter int COUNT_W = voting_pkg::COUNT_W,
  parameter int TOTAL_W = voting_pkg::TOTAL_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mode,
  input  logic [COUNT_W-1:0] cand1_vote_recvd,
  input  logic [COUNT_W-1:0] cand2_vote_recvd,
  input  logic [COUNT_W-1:0] cand3_vote_recvd,
  input  logic [COUNT_W-1:0] cand4_vote_recvd,
  output logic               busy,
  output logic               result_valid,
  output logic [1:0]         winner,
  output logic [COUNT_W-1:0] winner_votes,
  output logic [3:0]         tie_mask,
  output logic               tie,
  output logic [TOTAL_W-1:0] total_votes
);

  import voting_pkg::*;

  // ---------------------------------------------------------------------------
  // State and working registers
  // ---------------------------------------------------------------------------
  state_t               r_state;
  state_t               w_state_next;
  logic                 r_mode_d;
  logic                 w_start;

  logic [COUNT_W-1:0]   r_snap [NUM_CAND];
  cand_idx_t            r_idx;

  // Running best/tie/sum while scanning; published only when the scan ends so
  // an aborted scan never exposes a partial result.
  logic [COUNT_W-1:0]   r_best;
  cand_idx_t            r_win;
  logic [NUM_CAND-1:0]  r_mask;
  logic [TOTAL_W-1:0]   r_acc;

  logic [COUNT_W-1:0]   w_cur;
  logic [NUM_CAND-1:0]  w_onehot;
  logic [COUNT_W-1:0]   w_best;
  cand_idx_t            w_win;
  logic [NUM_CAND-1:0]  w_mask;
  logic [TOTAL_W-1:0]   w_acc;

  assign w_start = mode & ~r_mode_d;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking (=) here would create order-dependent races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. Leaving result mode returns to IDLE from any state.
  // ---------------------------------------------------------------------------
  // NOTE: default assignment first so every path drives w_state_next;
  // a missing branch would otherwise infer a latch.
  always_comb begin
    w_state_next = r_state;
    if (!mode) begin
      w_state_next = IDLE;
    end else begin
      unique case (r_state)
        IDLE:    if (w_start) w_state_next = SCAN;
        SCAN:    if (r_idx == cand_idx_t'(NUM_CAND - 1)) w_state_next = DONE;
        DONE:    w_state_next = DONE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Compare/accumulate step for the candidate at r_idx
  // ---------------------------------------------------------------------------
  always_comb begin
    w_cur    = r_snap[r_idx];
    w_onehot = NUM_CAND'(1) << r_idx;
    w_best   = r_best;
    w_win    = r_win;
    w_mask   = r_mask;
    w_acc    = r_acc + TOTAL_W'(w_cur);
    if (r_idx == '0) begin
      // First candidate seeds the search and restarts the sum.
      w_best = w_cur;
      w_win  = '0;
      w_mask = NUM_CAND'(1);
      w_acc  = TOTAL_W'(w_cur);
    end else if (w_cur > r_best) begin
      w_best = w_cur;
      w_win  = r_idx;
      w_mask = w_onehot;
    end else if (w_cur == r_best) begin
      // Equal count joins the tie set; earlier index keeps the win.
      w_mask = r_mask | w_onehot;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath and output registers
  // ---------------------------------------------------------------------------
  // NOTE: the snapshot array is only four words and must read as zero after
  // reset, so it is reset like ordinary flops rather than left as memory.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode_d     <= 1'b0;
      r_idx        <= '0;
      r_best       <= '0;
      r_win        <= '0;
      r_mask       <= '0;
      r_acc        <= '0;
      for (int i = 0; i < NUM_CAND; i++) r_snap[i] <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      winner       <= '0;
      winner_votes <= '0;
      tie_mask     <= '0;
      tie          <= 1'b0;
      total_votes  <= '0;
    end else begin
      r_mode_d <= mode;
      if (!mode) begin
        busy         <= 1'b0;
        result_valid <= 1'b0;
        winner       <= '0;
        winner_votes <= '0;
        tie_mask     <= '0;
        tie          <= 1'b0;
        total_votes  <= '0;
      end else if (r_state == IDLE && w_start) begin
        r_snap[0]    <= cand1_vote_recvd;
        r_snap[1]    <= cand2_vote_recvd;
        r_snap[2]    <= cand3_vote_recvd;
        r_snap[3]    <= cand4_vote_recvd;
        r_idx        <= '0;
        busy         <= 1'b1;
        result_valid <= 1'b0;
        winner       <= '0;
        winner_votes <= '0;
        tie_mask     <= '0;
        tie          <= 1'b0;
        total_votes  <= '0;
      end else if (r_state == SCAN) begin
        r_best <= w_best;
        r_win  <= w_win;
        r_mask <= w_mask;
        r_acc  <= w_acc;
        r_idx  <= r_idx + cand_idx_t'(1);
        if (r_idx == cand_idx_t'(NUM_CAND - 1)) begin
          busy         <= 1'b0;
          result_valid <= 1'b1;
          winner       <= w_win;
          winner_votes <= w_best;
          tie_mask     <= w_mask;
          tie          <= multi_bit_set(w_mask);
          total_votes  <= w_acc;
        end
      end
    end
  end

endmodule

// File: tb/tb_vote_result_evaluator.sv
// -----------------------------------------------------------------------------
// tb_vote_result_evaluator
// Directed and randomized scenarios for vote_result_evaluator. Expected
// results come from literal values or from a plain max/sum reference model.
// -----------------------------------------------------------------------------
module tb_vote_result_evaluator;

  localparam int CW = 8;
  localparam int TW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          mode;
  logic [CW-1:0] c1, c2, c3, c4;
  logic          busy;
  logic          result_valid;
  logic [1:0]    winner;
  logic [CW-1:0] winner_votes;
  logic [3:0]    tie_mask;
  logic          tie;
  logic [TW-1:0] total_votes;

  typedef struct packed {
    logic [1:0]    winner;
    logic [CW-1:0] votes;
    logic [3:0]    mask;
    logic          tie;
    logic [TW-1:0] total;
  } res_t;

  int n_checks = 0;
  int n_pass   = 0;

  vote_result_evaluator #(.COUNT_W(CW), .TOTAL_W(TW)) dut (
    .clk              (clk),
    .reset            (reset),
    .mode             (mode),
    .cand1_vote_recvd (c1),
    .cand2_vote_recvd (c2),
    .cand3_vote_recvd (c3),
    .cand4_vote_recvd (c4),
    .busy             (busy),
    .result_valid     (result_valid),
    .winner           (winner),
    .winner_votes     (winner_votes),
    .tie_mask         (tie_mask),
    .tie              (tie),
    .total_votes      (total_votes)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Helpers (stimulus, observation, reference model)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic res_t observed();
    res_t r;
    r.winner = winner;
    r.votes  = winner_votes;
    r.mask   = tie_mask;
    r.tie    = tie;
    r.total  = total_votes;
    return r;
  endfunction

  function automatic res_t mk(input int w, input int v, input logic [3:0] m,
                              input logic t, input int tot);
    res_t r;
    r.winner = 2'(w);
    r.votes  = CW'(v);
    r.mask   = m;
    r.tie    = t;
    r.total  = TW'(tot);
    return r;
  endfunction

  // Winner = lowest index holding the maximum; tie when several hold it.
  function automatic res_t model(input int c[4]);
    res_t r;
    int   mx  = -1;
    int   n   = 0;
    int   sum = 0;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      sum += c[i];
      if (c[i] > mx) mx = c[i];
    end
    for (int i = 0; i < 4; i++) begin
      if (c[i] == mx) begin
        r.mask[i] = 1'b1;
        if (n == 0) r.winner = 2'(i);
        n++;
      end
    end
    r.votes = CW'(mx);
    r.tie   = (n > 1);
    r.total = TW'(sum);
    return r;
  endfunction

  task automatic set_counts(input int c[4]);
    c1 = CW'(c[0]);
    c2 = CW'(c[1]);
    c3 = CW'(c[2]);
    c4 = CW'(c[3]);
  endtask

  // Leave result mode for one edge, load counts, then raise mode.
  task automatic start_scan(input int c[4]);
    mode = 1'b0;
    tick();
    set_counts(c);
    mode = 1'b1;
  endtask

  // Counts edges until result_valid (bounded). cycles = -1 on timeout.
  // Optionally replaces the counts after edge number chg_at.
  task automatic wait_result(input int chg_at, input int chg[4],
                             output int cycles, output int busy_cnt);
    cycles   = -1;
    busy_cnt = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == chg_at) set_counts(chg);
      if (busy) busy_cnt++;
      if (result_valid) begin
        cycles = i;
        break;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1;
    mode  = 1'b0;
    c1 = '0; c2 = '0; c3 = '0; c4 = '0;
    #3;
    n_checks++;
    if ({busy, result_valid, observed()} !== '0)
      $display("FAIL reset_async: got busy=%b valid=%b res=%h want all zero",
               busy, result_valid, observed());
    else n_pass++;
    tick();
    tick();
    n_checks++;
    if ({busy, result_valid, observed()} !== '0)
      $display("FAIL reset_held: got busy=%b valid=%b res=%h want all zero",
               busy, result_valid, observed());
    else n_pass++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_directed(input string name, input int c[4], input res_t exp);
    int cyc, bsy;
    int none[4] = '{0, 0, 0, 0};
    start_scan(c);
    wait_result(-1, none, cyc, bsy);
    n_checks++;
    if (cyc !== 5) $display("FAIL %s_latency: got %0d edges want 5", name, cyc);
    else n_pass++;
    n_checks++;
    if (bsy !== 4) $display("FAIL %s_busy: got %0d busy cycles want 4", name, bsy);
    else n_pass++;
    n_checks++;
    if (observed() !== exp)
      $display("FAIL %s_result: got %h want %h", name, observed(), exp);
    else n_pass++;
  endtask

  task automatic test_snapshot_isolation();
    int cyc, bsy;
    int c[4]   = '{1, 2, 3, 4};
    int chg[4] = '{9, 9, 9, 9};
    res_t exp  = mk(3, 4, 4'b1000, 1'b0, 10);
    start_scan(c);
    // Edge 3 is E2, so the new counts arrive two cycles into the scan.
    wait_result(3, chg, cyc, bsy);
    n_checks++;
    if (cyc !== 5) $display("FAIL snap_latency: got %0d edges want 5", cyc);
    else n_pass++;
    n_checks++;
    if (observed() !== exp)
      $display("FAIL snap_result: got %h want %h", observed(), exp);
    else n_pass++;
    for (int i = 0; i < 3; i++) tick();
    n_checks++;
    if ({result_valid, observed()} !== {1'b1, exp})
      $display("FAIL snap_hold: got valid=%b res=%h want valid=1 res=%h",
               result_valid, observed(), exp);
    else n_pass++;
  endtask

  task automatic test_abort();
    int   c[4]  = '{6, 1, 8, 3};
    logic saw_v = 1'b0;
    start_scan(c);
    tick();  // E0
    tick();  // E1
    tick();  // E2
    mode = 1'b0;
    tick();
    n_checks++;
    if ({busy, result_valid, observed()} !== '0)
      $display("FAIL abort_clear: got busy=%b valid=%b res=%h want all zero",
               busy, result_valid, observed());
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      tick();
      saw_v |= result_valid;
    end
    n_checks++;
    if (saw_v !== 1'b0) $display("FAIL abort_no_valid: got valid seen=%b want 0", saw_v);
    else n_pass++;
  endtask

  task automatic test_async_reset_done();
    int cyc, bsy;
    int c[4]    = '{3, 8, 8, 1};
    int none[4] = '{0, 0, 0, 0};
    start_scan(c);
    wait_result(-1, none, cyc, bsy);
    n_checks++;
    if (result_valid !== 1'b1) $display("FAIL rst_done_pre: got valid=%b want 1", result_valid);
    else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({busy, result_valid, observed()} !== '0)
      $display("FAIL rst_done_async: got busy=%b valid=%b res=%h want all zero",
               busy, result_valid, observed());
    else n_pass++;
    tick();
    #2 reset = 1'b0;
    // mode is still 1: the first edge after release must start a new scan.
    wait_result(-1, none, cyc, bsy);
    n_checks++;
    if (cyc !== 5) $display("FAIL rst_release_latency: got %0d edges want 5", cyc);
    else n_pass++;
    n_checks++;
    if (observed() !== model(c))
      $display("FAIL rst_release_result: got %h want %h", observed(), model(c));
    else n_pass++;
  endtask

  task automatic test_all_zero_and_fall();
    int c[4] = '{0, 0, 0, 0};
    test_directed("all_zero", c, mk(0, 0, 4'b1111, 1'b1, 0));
    mode = 1'b0;
    tick();
    n_checks++;
    if ({busy, result_valid, observed()} !== '0)
      $display("FAIL mode_fall_clear: got busy=%b valid=%b res=%h want all zero",
               busy, result_valid, observed());
    else n_pass++;
  endtask

  // Back-to-back reruns: each iteration drops mode for a single edge.
  task automatic test_back_to_back_random();
    int cyc, bsy;
    int c[4];
    int none[4] = '{0, 0, 0, 0};
    for (int it = 0; it < 25; it++) begin
      for (int k = 0; k < 4; k++)
        c[k] = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3))
                                           : int'($urandom_range(0, 255));
      start_scan(c);
      wait_result(-1, none, cyc, bsy);
      n_checks++;
      if (cyc !== 5 || bsy !== 4)
        $display("FAIL rand%0d_timing: got %0d edges/%0d busy want 5/4", it, cyc, bsy);
      else n_pass++;
      n_checks++;
      if (observed() !== model(c))
        $display("FAIL rand%0d_result: counts %0d,%0d,%0d,%0d got %h want %h",
                 it, c[0], c[1], c[2], c[3], observed(), model(c));
      else n_pass++;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence
  // ---------------------------------------------------------------------------
  initial begin
    int t1[4] = '{5, 9, 3, 2};
    int t2[4] = '{7, 4, 7, 7};
    int t3[4] = '{255, 255, 255, 255};
    test_reset();
    test_directed("basic", t1, mk(1, 9, 4'b0010, 1'b0, 19));
    test_directed("tie3", t2, mk(0, 7, 4'b1101, 1'b1, 25));
    test_directed("max_counts", t3, mk(0, 255, 4'b1111, 1'b1, 1020));
    test_snapshot_isolation();
    test_abort();
    test_async_reset_done();
    test_all_zero_and_fall();
    test_back_to_back_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
